// File: rtl/debouncer_pkg.sv
// Shared constants and helpers for the multi-channel debouncer.
package debouncer_pkg;

  localparam int unsigned DEFAULT_DEBOUNCE_VALUE = 100;
  localparam int unsigned MAX_CHANNELS           = 32;

  // Wide enough to hold 0..value; the count itself only reaches value-1.
  function automatic int unsigned cnt_width(input int unsigned value);
    return $clog2(value + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// Single-line debounce filter: stable level plus one-cycle rise/fall events.
module debounce_channel
  import debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_VALUE = DEFAULT_DEBOUNCE_VALUE,
  parameter bit          RESET_VALUE    = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic sample,
  output logic stable,
  output logic rise,
  output logic fall,
  output logic qualify
);

  localparam int unsigned            CNT_WIDTH = cnt_width(DEBOUNCE_VALUE);
  localparam logic [CNT_WIDTH-1:0]   CNT_LAST  = CNT_WIDTH'(DEBOUNCE_VALUE - 1);

  logic [CNT_WIDTH-1:0] cnt;

  // High on the edge where the new level is accepted; the top registers
  // the OR of these so any_change lines up with the pulses.
  assign qualify = (sample != stable) && (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable <= RESET_VALUE;
      cnt    <= '0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (sample == stable) begin
        cnt <= '0;
      end else if (qualify) begin
        stable <= sample;
        cnt    <= '0;
        rise   <= sample;
        fall   <= ~sample;
      end else begin
        cnt <= cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/multi_debouncer.sv
// Multi-channel debouncer with per-channel rise/fall pulses and any_change.
// Optional two-flop input synchroniser enabled by defining DEBOUNCER_SYNC_EN.
module multi_debouncer
  import debouncer_pkg::*;
#(
  parameter int unsigned CHANNELS       = 4,
  parameter int unsigned DEBOUNCE_VALUE = DEFAULT_DEBOUNCE_VALUE,
  parameter bit          RESET_VALUE    = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] line,
  output logic [CHANNELS-1:0] debounced_line,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic                any_change
);

  logic [CHANNELS-1:0] sample;
  logic [CHANNELS-1:0] qualify;

`ifdef DEBOUNCER_SYNC_EN
  logic [CHANNELS-1:0] sync_q1;
  logic [CHANNELS-1:0] sync_q2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= {CHANNELS{RESET_VALUE}};
      sync_q2 <= {CHANNELS{RESET_VALUE}};
    end else begin
      sync_q1 <= line;
      sync_q2 <= sync_q1;
    end
  end

  assign sample = sync_q2;
`else
  // Inputs are assumed already synchronous to clk in this build.
  assign sample = line;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_VALUE (DEBOUNCE_VALUE),
      .RESET_VALUE    (RESET_VALUE)
    ) u_chan (
      .clk     (clk),
      .reset   (reset),
      .sample  (sample[i]),
      .stable  (debounced_line[i]),
      .rise    (rise_pulse[i]),
      .fall    (fall_pulse[i]),
      .qualify (qualify[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      any_change <= 1'b0;
    end else begin
      any_change <= |qualify;
    end
  end

endmodule
